// File: rtl/pll_reset_sequencer_if.sv
// PLL control/status bundle between the reset sequencer (master) and the PLL/system side (slave).
// fault_cnt reads as zero unless PLL_RST_SEQ_STATUS_EN is defined when the sequencer is built.
interface pll_reset_sequencer_if;
    logic       locked;
    logic       pll_rst;
    logic       sys_rst_n;
    logic [7:0] fault_cnt;

    modport master (
        input  locked,
        output pll_rst,
        output sys_rst_n,
        output fault_cnt
    );

    modport slave (
        output locked,
        input  pll_rst,
        input  sys_rst_n,
        input  fault_cnt
    );
endinterface

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock supervisor on refclk: pulses pll_rst, waits for stable lock, then releases sys_rst_n.
// Latency: locked rise to sys_rst_n rise is LOCK_STABLE_CYCLES+3 edges. No backpressure; macro PLL_RST_SEQ_STATUS_EN enables fault_cnt.
module pll_reset_sequencer #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 50000
) (
    input  logic                   refclk,
    input  logic                   rst_n,
    pll_reset_sequencer_if.master  pll
);

    localparam int MAX_PS = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
    localparam int MAX_C  = (MAX_PS > LOCK_TIMEOUT_CYCLES) ? MAX_PS : LOCK_TIMEOUT_CYCLES;
    localparam int CW     = $clog2(MAX_C);

    localparam logic [CW-1:0] RST_LAST     = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_PLL_RST   = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_STABLE    = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          pll_rst_q;
    logic          sys_rst_n_q;
    logic          locked_m;
    logic          locked_s;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            locked_m <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            locked_m <= pll.locked;
            locked_s <= locked_m;
        end
    end

    // Outputs are written on the same edge as the state change, so they always decode the current state.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_PLL_RST;
            cnt         <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
        end else begin
            case (state)
                ST_PLL_RST: begin
                    if (cnt == RST_LAST) begin
                        state     <= ST_WAIT_LOCK;
                        cnt       <= '0;
                        pll_rst_q <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    // Lock takes priority over a timeout landing on the same edge.
                    if (locked_s) begin
                        state <= ST_STABLE;
                        cnt   <= '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        state     <= ST_PLL_RST;
                        cnt       <= '0;
                        pll_rst_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_STABLE: begin
                    if (!locked_s) begin
                        state <= ST_WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        state       <= ST_RUN;
                        cnt         <= '0;
                        sys_rst_n_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!locked_s) begin
                        state       <= ST_PLL_RST;
                        cnt         <= '0;
                        pll_rst_q   <= 1'b1;
                        sys_rst_n_q <= 1'b0;
                    end
                end
                default: begin
                    state       <= ST_PLL_RST;
                    cnt         <= '0;
                    pll_rst_q   <= 1'b1;
                    sys_rst_n_q <= 1'b0;
                end
            endcase
        end
    end

    assign pll.pll_rst   = pll_rst_q;
    assign pll.sys_rst_n = sys_rst_n_q;

`ifdef PLL_RST_SEQ_STATUS_EN
    logic       fault_evt;
    logic [7:0] fault_q;

    assign fault_evt = !locked_s &&
                       ((state == ST_RUN) || ((state == ST_WAIT_LOCK) && (cnt == TIMEOUT_LAST)));

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q <= 8'd0;
        end else if (fault_evt && (fault_q != 8'hFF)) begin
            fault_q <= fault_q + 8'd1;
        end
    end

    assign pll.fault_cnt = fault_q;
`else
    assign pll.fault_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with shortened timing (P=4, L=16, T=20).
// Expected fault counts follow PLL_RST_SEQ_STATUS_EN; all other timing is identical in both builds.
module tb_pll_reset_sequencer;

    localparam int P = 4;
    localparam int L = 16;
    localparam int T = 20;

`ifdef PLL_RST_SEQ_STATUS_EN
    localparam bit STATUS_EN = 1'b1;
`else
    localparam bit STATUS_EN = 1'b0;
`endif

    logic refclk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    pll_reset_sequencer_if pll_if ();

    pll_reset_sequencer #(
        .PLL_RST_CYCLES      (P),
        .LOCK_STABLE_CYCLES  (L),
        .LOCK_TIMEOUT_CYCLES (T)
    ) dut (
        .refclk (refclk),
        .rst_n  (rst_n),
        .pll    (pll_if.master)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    function automatic logic [31:0] expf(input int n);
        return STATUS_EN ? 32'(n) : 32'd0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic edges(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    // Assert reset mid-cycle, verify the asynchronous effect, hold, then release.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check({tag, "_pll_rst"},   32'(pll_if.pll_rst),   32'd1);
        check({tag, "_sys_rst_n"}, 32'(pll_if.sys_rst_n), 32'd0);
        check({tag, "_fault"},     32'(pll_if.fault_cnt), 32'd0);
        edges(2);
        rst_n = 1'b1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b1;
        pll_if.locked = 1'b0;
        #2;
        do_reset("rst0");

        // Timeout retry with locked held low.
        edges(P - 1);
        check("s1_pll_rst_hold", 32'(pll_if.pll_rst), 32'd1);
        edges(1);
        check("s1_pll_rst_fall", 32'(pll_if.pll_rst), 32'd0);
        edges(T - 1);
        check("s1_pre_timeout_pll", 32'(pll_if.pll_rst), 32'd0);
        check("s1_pre_timeout_flt", 32'(pll_if.fault_cnt), 32'd0);
        edges(1);
        check("s1_timeout_pll", 32'(pll_if.pll_rst), 32'd1);
        check("s1_timeout_flt", 32'(pll_if.fault_cnt), expf(1));
        check("s1_sys_low", 32'(pll_if.sys_rst_n), 32'd0);

        // Clean lock acquisition.
        do_reset("rst1");
        edges(P);
        check("s2_wait_lock", 32'(pll_if.pll_rst), 32'd0);
        edges(5);
        pll_if.locked = 1'b1;
        edges(L + 2);
        check("s2_sys_before", 32'(pll_if.sys_rst_n), 32'd0);
        edges(1);
        check("s2_sys_rise", 32'(pll_if.sys_rst_n), 32'd1);
        check("s2_flt", 32'(pll_if.fault_cnt), 32'd0);

        // Lock loss in RUN.
        pll_if.locked = 1'b0;
        edges(2);
        check("s4_sys_still", 32'(pll_if.sys_rst_n), 32'd1);
        check("s4_pll_still", 32'(pll_if.pll_rst), 32'd0);
        edges(1);
        check("s4_sys_fall", 32'(pll_if.sys_rst_n), 32'd0);
        check("s4_pll_rise", 32'(pll_if.pll_rst), 32'd1);
        check("s4_flt", 32'(pll_if.fault_cnt), expf(1));

        // Re-lock with a 3-cycle dropout during STABLE.
        edges(P);
        check("s3_wait_lock", 32'(pll_if.pll_rst), 32'd0);
        pll_if.locked = 1'b1;
        edges(3 + 8);
        pll_if.locked = 1'b0;
        edges(3);
        pll_if.locked = 1'b1;
        check("s3_no_pll_rst", 32'(pll_if.pll_rst), 32'd0);
        check("s3_sys_low", 32'(pll_if.sys_rst_n), 32'd0);
        edges(L + 2);
        check("s3_sys_before", 32'(pll_if.sys_rst_n), 32'd0);
        check("s3_flt", 32'(pll_if.fault_cnt), expf(1));
        edges(1);
        check("s3_sys_rise", 32'(pll_if.sys_rst_n), 32'd1);

        // Lock arriving on the timeout edge wins.
        pll_if.locked = 1'b0;
        do_reset("rst2");
        edges(P + T - 3);
        pll_if.locked = 1'b1;
        edges(3);
        check("tie_pll_low", 32'(pll_if.pll_rst), 32'd0);
        check("tie_flt", 32'(pll_if.fault_cnt), 32'd0);
        edges(L - 1);
        check("tie_sys_before", 32'(pll_if.sys_rst_n), 32'd0);
        edges(1);
        check("tie_sys_rise", 32'(pll_if.sys_rst_n), 32'd1);

        // Saturation over 300 timeouts, then asynchronous reset mid-count.
        pll_if.locked = 1'b0;
        do_reset("rst3");
        edges(255 * (P + T) - 1);
        check("sat_254", 32'(pll_if.fault_cnt), expf(254));
        edges(1);
        check("sat_255", 32'(pll_if.fault_cnt), expf(255));
        edges(45 * (P + T) + 7);
        check("sat_hold", 32'(pll_if.fault_cnt), expf(255));
        check("sat_sys_low", 32'(pll_if.sys_rst_n), 32'd0);
        do_reset("rst4");
        edges(P);
        check("post_rst_pll_low", 32'(pll_if.pll_rst), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
